// File: rtl/flag_unit_if.sv
// Flag unit bus: pipeline control, EX result info and ID branch query in,
// flags / hazard request / hazard counter out.
//   master : drives stall, flush, ex_*, id_*; observes flags, flag_hazard, hazard_cnt
//   slave  : the flag unit itself
interface flag_unit_if;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned COND_W = 3;
  localparam int unsigned FLAG_W = 3;
  localparam int unsigned CNT_W  = 16;

  logic              stall;
  logic              flush;
  logic              ex_valid;
  logic [OP_W-1:0]   ex_opcode;
  logic [DATA_W-1:0] ex_result;
  logic              ex_ovfl;
  logic              id_branch;
  logic [COND_W-1:0] id_cond;
  logic [FLAG_W-1:0] flags;
  logic              flag_hazard;
  logic [CNT_W-1:0]  hazard_cnt;

  modport master (
    output stall, flush, ex_valid, ex_opcode, ex_result, ex_ovfl, id_branch, id_cond,
    input  flags, flag_hazard, hazard_cnt
  );

  modport slave (
    input  stall, flush, ex_valid, ex_opcode, ex_result, ex_ovfl, id_branch, id_cond,
    output flags, flag_hazard, hazard_cnt
  );
endinterface

// File: rtl/flag_unit.sv
// Flag unit: holds the {Z,V,N} condition flags written by EX-stage ALU ops,
// detects ID-stage branches that depend on flags still being produced in EX,
// and counts hazard cycles (saturating).
// Ports:
//   clk         system clock (rising edge)
//   rst_n       synchronous active-low reset
//   bus.slave   stall/flush/ex_*/id_* in; flags (reg), flag_hazard (comb),
//               hazard_cnt (reg) out
module flag_unit (
  input  logic         clk,
  input  logic         rst_n,
  flag_unit_if.slave   bus
);
  localparam int unsigned FLAG_W = 3;
  localparam int unsigned CNT_W  = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Flag bit positions: [2]=Z, [1]=V, [0]=N
  localparam logic [FLAG_W-1:0] M_ZVN  = 3'b111;
  localparam logic [FLAG_W-1:0] M_Z    = 3'b100;
  localparam logic [FLAG_W-1:0] M_V    = 3'b010;
  localparam logic [FLAG_W-1:0] M_N    = 3'b001;
  localparam logic [FLAG_W-1:0] M_ZN   = 3'b101;
  localparam logic [FLAG_W-1:0] M_NONE = 3'b000;

  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [CNT_W-1:0]  hazard_cnt_q, hazard_cnt_d;
  logic [FLAG_W-1:0] wr_mask;
  logic [FLAG_W-1:0] dep_mask;
  logic [FLAG_W-1:0] new_flags;
  logic              commit;
  logic              hazard;

  // Which flags the EX opcode writes
  always_comb begin
    wr_mask = M_NONE;
    case (bus.ex_opcode)
      4'b0000, 4'b0001:                   wr_mask = M_ZVN;
      4'b0010, 4'b0100, 4'b0101, 4'b0110: wr_mask = M_Z;
      default:                            wr_mask = M_NONE;
    endcase
  end

  // Which flags the ID branch condition reads
  always_comb begin
    dep_mask = M_NONE;
    case (bus.id_cond)
      3'b000, 3'b001:         dep_mask = M_Z;
      3'b010, 3'b100, 3'b101: dep_mask = M_ZN;
      3'b011:                 dep_mask = M_N;
      3'b110:                 dep_mask = M_V;
      default:                dep_mask = M_NONE;
    endcase
  end

  // Next-state: masked flag commit and saturating hazard counter
  always_comb begin
    new_flags    = {bus.ex_result == 16'h0000, bus.ex_ovfl, bus.ex_result[15]};
    commit       = bus.ex_valid & ~bus.stall & ~bus.flush;
    hazard       = bus.id_branch & bus.ex_valid & ~bus.flush & (|(dep_mask & wr_mask));
    flags_d      = flags_q;
    hazard_cnt_d = hazard_cnt_q;
    if (commit) begin
      flags_d = (new_flags & wr_mask) | (flags_q & ~wr_mask);
    end
    if (hazard && (hazard_cnt_q != CNT_MAX)) begin
      hazard_cnt_d = hazard_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q      <= M_NONE;
      hazard_cnt_q <= '0;
    end else begin
      flags_q      <= flags_d;
      hazard_cnt_q <= hazard_cnt_d;
    end
  end

  assign bus.flags       = flags_q;
  assign bus.flag_hazard = hazard;
  assign bus.hazard_cnt  = hazard_cnt_q;
endmodule

// File: tb/tb_flag_unit.sv
// Bench for flag_unit: directed vector table, randomized run against a
// rule-level model, and a saturating-counter sequence.
module tb_flag_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  flag_unit_if bus ();
  flag_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        rst_n, stall, flush, valid;
    logic [3:0]  op;
    logic [15:0] res;
    logic        ovfl, br;
    logic [2:0]  cond;
    logic        hz;
    logic [2:0]  fl;
    logic [15:0] cnt;
  } vec_t;

  vec_t vt[22];

  function automatic vec_t mk(logic r, logic s, logic f, logic v, logic [3:0] op,
                              logic [15:0] res, logic ov, logic br, logic [2:0] cond,
                              logic hz, logic [2:0] fl, logic [15:0] cnt);
    vec_t x;
    x.rst_n = r; x.stall = s; x.flush = f; x.valid = v; x.op = op; x.res = res;
    x.ovfl = ov; x.br = br; x.cond = cond; x.hz = hz; x.fl = fl; x.cnt = cnt;
    return x;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic f, input logic v,
                       input logic [3:0] op, input logic [15:0] res, input logic ov,
                       input logic br, input logic [2:0] cond);
    rst_n         = r;
    bus.stall     = s;
    bus.flush     = f;
    bus.ex_valid  = v;
    bus.ex_opcode = op;
    bus.ex_result = res;
    bus.ex_ovfl   = ov;
    bus.id_branch = br;
    bus.id_cond   = cond;
  endtask

  // Model state for the randomized phase
  logic [2:0]  m_flags;
  logic [15:0] m_cnt;

  initial begin
    // Directed table: hz checked before the edge, fl/cnt after it
    vt[0]  = mk(0,0,0,1, 4'h0, 16'h0000, 1, 0, 3'd0, 0, 3'b000, 16'd0);
    vt[1]  = mk(1,0,0,1, 4'h0, 16'h0000, 1, 0, 3'd0, 0, 3'b110, 16'd0);
    vt[2]  = mk(1,0,0,1, 4'h1, 16'h8000, 0, 0, 3'd0, 0, 3'b001, 16'd0);
    vt[3]  = mk(1,0,0,1, 4'h2, 16'h0000, 1, 0, 3'd0, 0, 3'b101, 16'd0);
    vt[4]  = mk(1,0,0,1, 4'h8, 16'h0000, 1, 0, 3'd0, 0, 3'b101, 16'd0);
    vt[5]  = mk(1,0,0,1, 4'h4, 16'h8001, 0, 0, 3'd0, 0, 3'b001, 16'd0);
    vt[6]  = mk(1,1,0,1, 4'h0, 16'h0000, 1, 1, 3'd3, 1, 3'b001, 16'd1);
    vt[7]  = mk(1,1,0,1, 4'h0, 16'h0000, 1, 1, 3'd7, 0, 3'b001, 16'd1);
    vt[8]  = mk(1,1,0,1, 4'h2, 16'h0000, 1, 1, 3'd6, 0, 3'b001, 16'd1);
    vt[9]  = mk(1,1,0,1, 4'h2, 16'h0000, 1, 1, 3'd0, 1, 3'b001, 16'd2);
    vt[10] = mk(1,1,0,1, 4'hA, 16'h0000, 1, 1, 3'd1, 0, 3'b001, 16'd2);
    vt[11] = mk(1,1,0,1, 4'h0, 16'h0000, 1, 0, 3'd3, 0, 3'b001, 16'd2);
    vt[12] = mk(0,0,0,0, 4'h0, 16'h1234, 0, 0, 3'd0, 0, 3'b000, 16'd0);
    vt[13] = mk(1,1,0,1, 4'h0, 16'h0000, 0, 1, 3'd1, 1, 3'b000, 16'd1);
    vt[14] = mk(1,0,1,1, 4'h0, 16'h0000, 0, 1, 3'd1, 0, 3'b000, 16'd1);
    vt[15] = mk(1,1,1,1, 4'h0, 16'h0000, 0, 1, 3'd1, 0, 3'b000, 16'd1);
    vt[16] = mk(1,0,0,1, 4'h0, 16'h0000, 0, 0, 3'd1, 0, 3'b100, 16'd1);
    vt[17] = mk(0,0,0,1, 4'h0, 16'h8000, 1, 1, 3'd6, 1, 3'b000, 16'd0);
    vt[18] = mk(1,0,0,1, 4'h0, 16'h8000, 1, 0, 3'd6, 0, 3'b011, 16'd0);
    vt[19] = mk(1,1,0,1, 4'h0, 16'h8000, 1, 1, 3'd0, 1, 3'b011, 16'd1);
    vt[20] = mk(1,1,0,1, 4'h0, 16'h8000, 1, 1, 3'd0, 1, 3'b011, 16'd2);
    vt[21] = mk(1,1,0,1, 4'h0, 16'h8000, 1, 1, 3'd0, 1, 3'b011, 16'd3);

    for (int i = 0; i < 22; i++) begin
      drive(vt[i].rst_n, vt[i].stall, vt[i].flush, vt[i].valid, vt[i].op,
            vt[i].res, vt[i].ovfl, vt[i].br, vt[i].cond);
      #1;
      chk($sformatf("vec%0d_hazard", i), 16'(bus.flag_hazard), 16'(vt[i].hz));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_flags", i), 16'(bus.flags), 16'(vt[i].fl));
      chk($sformatf("vec%0d_cnt", i), bus.hazard_cnt, vt[i].cnt);
    end

    // Randomized phase against a rule-level model
    drive(0,0,0,0, 4'h0, 16'h0, 0, 0, 3'd0);
    @(posedge clk); #1;
    m_flags = 3'b000;
    m_cnt   = 16'h0000;
    for (int i = 0; i < 400; i++) begin
      logic r, s, f, v, ov, br;
      logic [3:0]  op;
      logic [15:0] res;
      logic [2:0]  cond;
      logic z_wr, vn_wr, dep_z, dep_n, dep_v, exp_hz;
      r    = ($urandom_range(0, 31) != 0);
      s    = ($urandom_range(0, 3) == 0);
      f    = ($urandom_range(0, 4) == 0);
      v    = ($urandom_range(0, 5) != 0);
      op   = 4'($urandom_range(0, 15));
      res  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      ov   = 1'($urandom_range(0, 1));
      br   = 1'($urandom_range(0, 1));
      cond = 3'($urandom_range(0, 7));
      drive(r, s, f, v, op, res, ov, br, cond);

      z_wr   = op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6};
      vn_wr  = op inside {4'd0, 4'd1};
      dep_z  = cond inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      dep_n  = cond inside {3'd2, 3'd3, 3'd4, 3'd5};
      dep_v  = (cond == 3'd6);
      exp_hz = br && v && !f && ((dep_z && z_wr) || ((dep_n || dep_v) && vn_wr));

      #1;
      chk("rand_hazard", 16'(bus.flag_hazard), 16'(exp_hz));

      if (!r) begin
        m_flags = 3'b000;
        m_cnt   = 16'h0000;
      end else begin
        if (v && !s && !f) begin
          if (z_wr)  m_flags[2] = (res == 16'h0000);
          if (vn_wr) begin
            m_flags[1] = ov;
            m_flags[0] = res[15];
          end
        end
        if (exp_hz && m_cnt < 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      @(posedge clk); #1;
      chk("rand_flags", 16'(bus.flags), 16'(m_flags));
      chk("rand_cnt", bus.hazard_cnt, m_cnt);
    end

    // Saturation: count up to FFFE, then three more hazard cycles
    drive(0,0,0,0, 4'h0, 16'h0, 0, 0, 3'd0);
    @(posedge clk); #1;
    chk("sat_reset_cnt", bus.hazard_cnt, 16'h0000);
    drive(1,1,0,1, 4'h0, 16'h0000, 0, 1, 3'd0);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", bus.hazard_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("sat_ffff_%0d", i), bus.hazard_cnt, 16'hFFFF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/flag_unit.md
FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 The module SHALL have exactly one clock, clk, and one reset, rst_n, which is synchronous and active-low.
REQ-002 The parameter list SHALL be: none (all widths fixed).
REQ-003 clk  input  1  system clock; all state SHALL change only on its rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 stall  input  1  pipeline hold; while high the EX instruction SHALL NOT commit flags.
REQ-006 flush  input  1  squash of the EX-stage instruction.
REQ-007 ex_valid  input  1  EX stage holds a live instruction.
REQ-008 ex_opcode  input  4  EX instruction opcode.
REQ-009 ex_result  input  16  ALU result of the EX instruction.
REQ-010 ex_ovfl  input  1  ALU signed-overflow indication for ex_result.
REQ-011 id_branch  input  1  ID stage holds a conditional branch (B or BR).
REQ-012 id_cond  input  3  condition code of the ID-stage branch.
REQ-013 flags  output  3  registered {Z,V,N}: bit2 = Z, bit1 = V, bit0 = N; this output feeds the branch unit's F input.
REQ-014 flag_hazard  output  1  combinational request to stall ID for one cycle.
REQ-015 hazard_cnt  output  16  registered count of hazard cycles.

Function
REQ-016 Z_new SHALL be (ex_result == 16'h0000), N_new SHALL be ex_result[15], and V_new SHALL be ex_ovfl.
REQ-017 Opcodes 0000 (ADD) and 0001 (SUB) SHALL write all of Z, V and N.
REQ-018 Opcodes 0010 (XOR), 0100 (SLL), 0101 (SRA) and 0110 (ROR) SHALL write Z only; V and N SHALL hold their values.
REQ-019 All other opcodes SHALL write no flag.
REQ-020 Commit: at a rising edge with ex_valid=1, stall=0 and flush=0, the masked bits SHALL update; flags SHALL show the new value the following cycle (latency 1).
REQ-021 When stall=1 or flush=1, flags SHALL hold; when both are high, flush wins and there is no update.
REQ-022 Dependency set per id_cond SHALL be:
  - 000 NE {Z}
  - 001 EQ {Z}
  - 010 GT {Z,N}
  - 011 LT {N}
  - 100 GTE {Z,N}
  - 101 LTE {Z,N}
  - 110 OVFL {V}
  - 111 unconditional {} (empty)
REQ-023 flag_hazard SHALL equal id_branch & ex_valid & ~flush & (dependency set ∩ EX write set is non-empty).
REQ-024 flag_hazard SHALL be independent of stall.
REQ-025 hazard_cnt SHALL increment by 1 at each rising edge where flag_hazard=1.
REQ-026 hazard_cnt SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-027 No output SHALL have X or Z values after reset; the flag write mask and the dependency set SHALL be purely combinational from the current inputs.

Reset
REQ-028 At a rising edge with rst_n=0, flags SHALL become 3'b000 and hazard_cnt SHALL become 16'h0000, regardless of stall, flush or ex_valid.
REQ-029 Reset asserted together with a commit SHALL discard the commit.
REQ-030 flag_hazard SHALL remain combinational during reset.
REQ-031 The first commit SHALL be possible at the first edge after rst_n returns high.

Verification
REQ-032 Reset: rst_n=0 with ex_valid=1, ADD, result 0, ovfl=1 for 1 edge -> flags=000, hazard_cnt=0000.
REQ-033 Full update:
  - ADD, result 16'h0000, ovfl=1 -> flags=110 next cycle.
  - Then SUB, result 16'h8000, ovfl=0 -> flags=001.
REQ-034 Partial and none update, starting from flags=001:
  - XOR, result 0, ovfl=1 -> flags=101.
  - Then LW (1000), result 0 -> flags stay 101.
  - Then SLL, result 16'h8001 -> flags=001.
REQ-035 Hazard:
  - EX ADD valid with id_branch=1: cond=011 -> flag_hazard=1; cond=111 -> 0.
  - EX XOR valid: cond=110 -> 0; cond=000 -> 1.
  - EX LLB valid, any cond -> 0.
  - id_branch=0 -> 0.
REQ-036 Stall/flush, starting from flags=000:
  - ADD, result 0 with stall=1 -> flags stay 000.
  - With flush=1 -> flags 000 and flag_hazard=0.
  - With stall=flush=1 -> flags 000.
  - Release both -> flags=100.
REQ-037 Counter:
  - 3 hazard cycles -> hazard_cnt=3.
  - Preload to FFFE, then 3 hazard cycles -> FFFF, held.
